// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM BIST controller.
// Optional macro RAM_BIST_ERR_COUNT_EN adds a saturating mismatch counter.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE, W0, R0, W1, R1, CHECK, DONE, FAIL
  } state_e;

  localparam int unsigned BG_W = 64;
  localparam logic [BG_W-1:0] BG = {8{8'h55}};

  // Background pattern for an address; callers truncate to the RAM width.
  function automatic logic [BG_W-1:0] bist_pat(input logic [BG_W-1:0] a);
    return a ^ BG;
  endfunction

endpackage

// File: rtl/ram_bist_if.sv
// Dual-port RAM access bus driven by the BIST controller (master) into the RAM (slave).
interface ram_bist_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          write_enable;
  logic          read_enable;
  logic [AW-1:0] write_address;
  logic [AW-1:0] read_address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  modport master (
    output write_enable, read_enable, write_address, read_address, data_in,
    input  data_out
  );
  modport slave (
    input  write_enable, read_enable, write_address, read_address, data_in,
    output data_out
  );
endinterface

// File: rtl/ram_bist_checker.sv
// Read-compare pipeline stage with first-mismatch capture.
// With RAM_BIST_ERR_COUNT_EN defined it also keeps a saturating mismatch count.
module ram_bist_checker
  import ram_bist_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] exp_i,
  input  logic [DW-1:0] data_i,
  output logic          mismatch_c_o,
  output logic          fail_seen_o,
  output logic [AW-1:0] fail_addr_o,
  output logic [DW-1:0] fail_exp_o,
  output logic [DW-1:0] fail_act_o
`ifdef RAM_BIST_ERR_COUNT_EN
  ,
  output logic [AW+1:0] err_count_o
`endif
);

  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] exp_q;

  // Compare happens the cycle after the read strobe, when RAM data is valid.
  assign mismatch_c_o = valid_q && (data_i != exp_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      exp_q   <= '0;
    end else begin
      valid_q <= valid_i;
      addr_q  <= addr_i;
      exp_q   <= exp_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clr_i) begin
      fail_seen_o <= 1'b0;
      fail_addr_o <= '0;
      fail_exp_o  <= '0;
      fail_act_o  <= '0;
    end else if (mismatch_c_o && !fail_seen_o) begin
      fail_seen_o <= 1'b1;
      fail_addr_o <= addr_q;
      fail_exp_o  <= exp_q;
      fail_act_o  <= data_i;
    end
  end

`ifdef RAM_BIST_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset || clr_i) begin
      err_count_o <= '0;
    end else if (mismatch_c_o && (err_count_o != '1)) begin
      err_count_o <= err_count_o + (AW+2)'(1);
    end
  end
`endif

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-style RAM BIST: write/read pattern, then write/read its complement.
// RAM_BIST_ERR_COUNT_EN defined: run to completion and count mismatches; else stop at first.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned RAM_width    = 8,
  parameter int unsigned RAM_depth    = 256,
  parameter int unsigned address_size = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  ram_bist_if.master              ram,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [address_size-1:0] fail_address,
  output logic [RAM_width-1:0]    fail_expected,
  output logic [RAM_width-1:0]    fail_actual
`ifdef RAM_BIST_ERR_COUNT_EN
  ,
  output logic [address_size+1:0] err_count
`endif
);

  localparam int unsigned AW = address_size;
  localparam int unsigned DW = RAM_width;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d, re_q, re_d;
  logic [AW-1:0] wa_q, wa_d, ra_q, ra_d;
  logic [DW-1:0] din_q, din_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic          last_c, accept_c, abort_c, mismatch_c, fail_seen;
  logic [DW-1:0] pat_c, rpat_c, exp_c;

  assign last_c   = (addr_q == AW'(RAM_depth - 1));
  assign accept_c = start && (state_q inside {IDLE, DONE, FAIL});

`ifdef RAM_BIST_ERR_COUNT_EN
  assign abort_c = 1'b0;
`else
  assign abort_c = mismatch_c;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE, DONE, FAIL: begin
        if (accept_c) begin
          state_d = W0;
          addr_d  = '0;
        end
      end
      W0, R0, W1, R1: begin
        addr_d = last_c ? '0 : addr_q + AW'(1);
        if (last_c) begin
          case (state_q)
            W0:      state_d = R0;
            R0:      state_d = W1;
            W1:      state_d = R1;
            default: state_d = CHECK;
          endcase
        end
      end
      CHECK:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort_c && (state_q inside {W0, R0, W1, R1, CHECK})) begin
      state_d = FAIL;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    pat_c  = DW'(bist_pat(64'(addr_d)));
    we_d   = 1'b0;
    re_d   = 1'b0;
    wa_d   = wa_q;
    ra_d   = ra_q;
    din_d  = din_q;
    case (state_d)
      W0: begin
        we_d  = 1'b1;
        wa_d  = addr_d;
        din_d = pat_c;
      end
      W1: begin
        we_d  = 1'b1;
        wa_d  = addr_d;
        din_d = ~pat_c;
      end
      R0, R1: begin
        re_d = 1'b1;
        ra_d = addr_d;
      end
      default: ;
    endcase
    busy_d = state_d inside {W0, R0, W1, R1, CHECK};
    done_d = state_d inside {DONE, FAIL};
    pass_d = (state_d == DONE) && !(fail_seen || mismatch_c);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      wa_q   <= '0;
      ra_q   <= '0;
      din_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      we_q   <= we_d;
      re_q   <= re_d;
      wa_q   <= wa_d;
      ra_q   <= ra_d;
      din_q  <= din_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  // Expected data for the read being issued this cycle.
  always_comb begin
    rpat_c = DW'(bist_pat(64'(ra_q)));
    exp_c  = (state_q == R1) ? ~rpat_c : rpat_c;
  end

  ram_bist_checker #(.AW(AW), .DW(DW)) u_checker (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (accept_c),
    .valid_i      (re_q),
    .addr_i       (ra_q),
    .exp_i        (exp_c),
    .data_i       (ram.data_out),
    .mismatch_c_o (mismatch_c),
    .fail_seen_o  (fail_seen),
    .fail_addr_o  (fail_address),
    .fail_exp_o   (fail_expected),
    .fail_act_o   (fail_actual)
`ifdef RAM_BIST_ERR_COUNT_EN
    ,
    .err_count_o  (err_count)
`endif
  );

  assign ram.write_enable  = we_q;
  assign ram.read_enable   = re_q;
  assign ram.write_address = wa_q;
  assign ram.read_address  = ra_q;
  assign ram.data_in       = din_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;

endmodule
